fetch_unit: RTL and testbench

Instruction fetch stage driven by the one-hot stage strobes of the control sequencer. On each fetch strobe it issues one read of the program memory at the current PC over a req/ack handshake. It latches the returned word into an instruction register for decode. On each writeback strobe it advances the PC by one or redirects it to a branch target.

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one program-memory read per fetch strobe over a
// req/ack handshake, latches the returned word, and advances or redirects the PC on writeback.
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_clk,
   input  logic                  wrbk_clk,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  busy,
   output logic                  fetch_overrun
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t state, state_next;
   logic   accept;
   logic   complete;
   logic   overrun;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // A strobe in WAIT is dropped and flagged even if the ack completes the fetch on the same edge.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      complete   = 1'b0;
      overrun    = 1'b0;
      case (state)
         IDLE: begin
            if (fetch_clk) begin
               accept     = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (mem_ack) begin
               complete   = 1'b1;
               state_next = IDLE;
            end
            if (fetch_clk) overrun = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // mem_addr is its own register, so a PC update during WAIT leaves the outstanding request intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req       <= 1'b0;
         mem_addr      <= '0;
         pc            <= RESET_PC;
         instr         <= '0;
         instr_pc      <= '0;
         instr_valid   <= 1'b0;
         busy          <= 1'b0;
         fetch_overrun <= 1'b0;
      end else begin
         busy <= (state_next == WAIT);
         if (accept) begin
            mem_addr    <= pc;
            mem_req     <= 1'b1;
            instr_valid <= 1'b0;
         end
         if (complete) begin
            instr       <= mem_rdata;
            instr_pc    <= mem_addr;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
         end
         if (overrun) fetch_overrun <= 1'b1;
         if (wrbk_clk) pc <= branch_taken ? branch_target : pc + PC_STEP;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetches are queued when a strobe is accepted
// and compared when instr_valid rises; a second instance checks RESET_PC and wrap.
module tb_fetch_unit;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_clk = 1'b0;
   logic        wrbk_clk = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = '0;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;

   logic        mem_req, instr_valid, busy, fetch_overrun;
   logic [15:0] mem_addr, instr, instr_pc, pc;
   logic        hi_mem_req, hi_instr_valid, hi_busy, hi_fetch_overrun;
   logic [15:0] hi_mem_addr, hi_instr, hi_instr_pc, hi_pc;

   exp_t        sb[$];
   exp_t        last_exp;
   logic [15:0] model_pc = '0;
   logic [15:0] data_base = 16'hA000;
   int          vectors = 0;
   int          miscompares = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .fetch_clk(fetch_clk), .wrbk_clk(wrbk_clk),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .pc(pc), .busy(busy), .fetch_overrun(fetch_overrun)
   );

   fetch_unit #(.RESET_PC(16'hFFFF)) dut_hi (
      .clk(clk), .rst(rst), .fetch_clk(fetch_clk), .wrbk_clk(wrbk_clk),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .mem_req(hi_mem_req), .mem_addr(hi_mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr(hi_instr), .instr_pc(hi_instr_pc), .instr_valid(hi_instr_valid),
      .pc(hi_pc), .busy(hi_busy), .fetch_overrun(hi_fetch_overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic popAndCompare();
      exp_t e;
      if (sb.size() == 0) begin
         checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         checkOutput("instr", {16'h0, instr}, {16'h0, e.instr});
         checkOutput("instr_pc", {16'h0, instr_pc}, {16'h0, e.pc});
         last_exp = e;
      end
   endtask

   task automatic checkResetValues();
      checkOutput("rst_mem_req", {31'h0, mem_req}, 32'd0);
      checkOutput("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
      checkOutput("rst_pc", {16'h0, pc}, 32'd0);
      checkOutput("rst_hi_pc", {16'h0, hi_pc}, 32'h0000FFFF);
      checkOutput("rst_instr", {16'h0, instr}, 32'd0);
      checkOutput("rst_instr_pc", {16'h0, instr_pc}, 32'd0);
      checkOutput("rst_valid", {31'h0, instr_valid}, 32'd0);
      checkOutput("rst_busy", {31'h0, busy}, 32'd0);
      checkOutput("rst_overrun", {31'h0, fetch_overrun}, 32'd0);
   endtask

   // One complete fetch from IDLE with the given number of ack-low cycles.
   task automatic applyStimulus(input int wait_cycles);
      exp_t e;
      fetch_clk = 1'b1;
      tick();
      fetch_clk = 1'b0;
      e.pc    = model_pc;
      e.instr = data_base + model_pc;
      sb.push_back(e);
      checkOutput("req_rise", {31'h0, mem_req}, 32'd1);
      checkOutput("mem_addr", {16'h0, mem_addr}, {16'h0, e.pc});
      checkOutput("busy_rise", {31'h0, busy}, 32'd1);
      checkOutput("valid_clear", {31'h0, instr_valid}, 32'd0);
      for (int i = 0; i < wait_cycles; i++) begin
         tick();
         checkOutput("req_hold", {31'h0, mem_req}, 32'd1);
         checkOutput("addr_hold", {16'h0, mem_addr}, {16'h0, e.pc});
         checkOutput("busy_hold", {31'h0, busy}, 32'd1);
         checkOutput("valid_wait", {31'h0, instr_valid}, 32'd0);
      end
      mem_ack   = 1'b1;
      mem_rdata = data_base + mem_addr;
      tick();
      mem_ack = 1'b0;
      checkOutput("valid_rise", {31'h0, instr_valid}, 32'd1);
      checkOutput("req_fall", {31'h0, mem_req}, 32'd0);
      checkOutput("busy_fall", {31'h0, busy}, 32'd0);
      popAndCompare();
   endtask

   task automatic applyWriteback(input logic taken, input logic [15:0] target);
      wrbk_clk      = 1'b1;
      branch_taken  = taken;
      branch_target = target;
      tick();
      wrbk_clk     = 1'b0;
      branch_taken = 1'b0;
      model_pc     = taken ? target : model_pc + 16'd1;
      checkOutput("pc_update", {16'h0, pc}, {16'h0, model_pc});
   endtask

   initial begin
      exp_t e;
      tick();
      tick();
      rst = 1'b0;
      checkResetValues();

      // Sequential zero-wait fetches; the high-reset instance wraps FFFF -> 0000.
      applyStimulus(0);
      checkOutput("hi_first_addr", {16'h0, hi_mem_addr}, 32'h0000FFFF);
      applyWriteback(1'b0, 16'h0);
      checkOutput("hi_pc_wrap", {16'h0, hi_pc}, 32'd0);
      applyStimulus(0);
      checkOutput("hi_wrap_addr", {16'h0, hi_mem_addr}, 32'd0);
      applyWriteback(1'b0, 16'h0);
      applyStimulus(0);

      applyWriteback(1'b0, 16'h0);
      applyStimulus(3);

      applyWriteback(1'b1, 16'h0040);
      applyStimulus(0);
      applyWriteback(1'b0, 16'h0);
      applyStimulus(0);

      applyWriteback(1'b1, 16'hFFFF);
      applyStimulus(1);
      applyWriteback(1'b0, 16'h0);
      applyStimulus(0);

      // Fetch and writeback on the same edge: fetch sees the old pc.
      fetch_clk = 1'b1;
      wrbk_clk  = 1'b1;
      tick();
      fetch_clk = 1'b0;
      wrbk_clk  = 1'b0;
      e.pc    = model_pc;
      e.instr = data_base + model_pc;
      sb.push_back(e);
      checkOutput("simul_addr", {16'h0, mem_addr}, {16'h0, model_pc});
      model_pc = model_pc + 16'd1;
      checkOutput("simul_pc", {16'h0, pc}, {16'h0, model_pc});
      mem_ack   = 1'b1;
      mem_rdata = data_base + mem_addr;
      tick();
      mem_ack = 1'b0;
      checkOutput("simul_valid", {31'h0, instr_valid}, 32'd1);
      popAndCompare();

      // Stray ack in IDLE must not disturb anything.
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
      tick();
      mem_ack = 1'b0;
      checkOutput("idle_ack_instr", {16'h0, instr}, {16'h0, last_exp.instr});
      checkOutput("idle_ack_busy", {31'h0, busy}, 32'd0);
      checkOutput("idle_ack_req", {31'h0, mem_req}, 32'd0);

      // Overrun: strobe while waiting, then strobe coincident with the ack.
      fetch_clk = 1'b1;
      tick();
      fetch_clk = 1'b0;
      e.pc    = model_pc;
      e.instr = data_base + model_pc;
      sb.push_back(e);
      tick();
      checkOutput("pre_overrun", {31'h0, fetch_overrun}, 32'd0);
      fetch_clk = 1'b1;
      tick();
      fetch_clk = 1'b0;
      checkOutput("overrun_set", {31'h0, fetch_overrun}, 32'd1);
      checkOutput("overrun_addr", {16'h0, mem_addr}, {16'h0, e.pc});
      fetch_clk = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = data_base + mem_addr;
      tick();
      fetch_clk = 1'b0;
      mem_ack   = 1'b0;
      checkOutput("overrun_complete", {31'h0, instr_valid}, 32'd1);
      popAndCompare();
      tick();
      checkOutput("overrun_no_refetch", {31'h0, mem_req}, 32'd0);
      checkOutput("overrun_valid_hold", {31'h0, instr_valid}, 32'd1);
      applyWriteback(1'b0, 16'h0);
      applyStimulus(0);
      checkOutput("overrun_sticky", {31'h0, fetch_overrun}, 32'd1);

      // Reset in WAIT, then a late ack.
      fetch_clk = 1'b1;
      tick();
      fetch_clk = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_pc = 16'h0;
      checkResetValues();
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 1'b0;
      checkOutput("late_ack_valid", {31'h0, instr_valid}, 32'd0);
      checkOutput("late_ack_instr", {16'h0, instr}, 32'd0);
      checkOutput("late_ack_busy", {31'h0, busy}, 32'd0);
      applyStimulus(0);

      checkOutput("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
